muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_iter.sv | 41 ++++
 rtl/muldiv_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of unsigned shift-add multiply or restoring divide on a
// 2*WIDTH accumulator; purely combinational.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    ge       = 1'b0;
    acc_next = acc;
    if (!is_div) begin
      // Multiplier sits in the low half and is consumed LSB first.
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      // Dividend sits in the low half; quotient bits shift in at the bottom.
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      ge     = (rem_sh >= {1'b0, b});
      diff   = rem_sh[WIDTH-1:0] - b;
      if (ge) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit with architectural HI/LO registers.
// Handshake: start is taken on any edge while busy is low; done pulses one cycle when HI/LO hold the result.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  state_t             state_q;
  logic [CNT_W-1:0]   count_q;
  logic               is_div_q;
  logic               neg_q;
  logic               rs_neg_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q, done_q, dbz_q;

  logic [2*WIDTH-1:0] acc_d;
  logic               signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, rs_raw;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .a        (a_q),
    .b        (b_q),
    .acc_next (acc_d)
  );

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    rs_neg    = signed_op & rs_val[WIDTH-1];
    rt_neg    = signed_op & rt_val[WIDTH-1];
    rs_abs    = rs_neg ? -rs_val : rs_val;
    rt_abs    = rt_neg ? -rt_val : rt_val;
    prod_fix  = neg_q ? -acc_q : acc_q;
    quot_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rs_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // Dividend is rebuilt from its magnitude for the divide-by-zero HI value.
    rs_raw    = rs_neg_q ? -a_q : a_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= CALC;
            busy_q   <= 1'b1;
            count_q  <= '0;
            is_div_q <= op[1];
            neg_q    <= rs_neg ^ rt_neg;
            rs_neg_q <= rs_neg;
            a_q      <= rs_abs;
            b_q      <= rt_abs;
            acc_q    <= {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) state_q <= FIXUP;
        end
        FIXUP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (b_q == '0) begin
            hi_q  <= rs_raw;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state   = state_q;

endmodule
